// File: rtl/emif_csr_pkg.sv
// ============================================================================
// Module      : emif_csr_pkg
// Description : Shared types and constants for the EMIF feature CSR window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package emif_csr_pkg;

    typedef struct packed {
        logic [3:0]  feat_type;
        logic [7:0]  rsvd_hi;
        logic [3:0]  minor;
        logic [6:0]  rsvd_lo;
        logic        eol;
        logic [23:0] nxt_off;
        logic [3:0]  major;
        logic [11:0] id;
    } t_dfh;

    typedef struct packed {
        logic [39:0] rsvd;
        logic [7:0]  fail_seen;
        logic [7:0]  fail;
        logic [7:0]  success;
    } t_emif_status;

    typedef struct packed {
        logic [51:0] rsvd;
        logic [3:0]  num_ch;
        logic [7:0]  ch_mask;
    } t_emif_capability;

    localparam logic [11:0] EMIF_DFH_FEAT_ID       = 12'h9;
    localparam logic [31:0] EMIF_DFH_OFFSET        = 32'h0;
    localparam logic [31:0] EMIF_STATUS_OFFSET     = 32'h8;
    localparam logic [31:0] EMIF_CAPABILITY_OFFSET = 32'h10;

    localparam t_dfh EMIF_DFH_DEFAULT = '{
        feat_type : 4'h3,
        rsvd_hi   : 8'h0,
        minor     : 4'h0,
        rsvd_lo   : 7'h0,
        eol       : 1'b0,
        nxt_off   : 24'h00B000,
        major     : 4'h1,
        id        : EMIF_DFH_FEAT_ID
    };

endpackage

`default_nettype wire

// File: rtl/emif_csr_sync.sv
// ============================================================================
// Module      : emif_csr_sync
// Description : Parameterised-width two-flop synchroniser into the CSR clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module emif_csr_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/emif_feature_csr.sv
// ============================================================================
// Module      : emif_feature_csr
// Description : EMIF device-feature CSR responder (DFH, STATUS, CAPABILITY).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module emif_feature_csr
    import emif_csr_pkg::*;
#(
    parameter int          ADDR_W  = 12,
    parameter int          TAG_W   = 10,
    parameter int          NUM_CH  = 4,
    parameter logic [63:0] DFH_VAL = 64'h3_00000_00B000_1009
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] cal_success,
    input  logic [NUM_CH-1:0] cal_fail,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_data,
    output logic [TAG_W-1:0]  rsp_tag
);

    localparam logic [ADDR_W-4:0] c_dfh_word    = EMIF_DFH_OFFSET[ADDR_W-1:3];
    localparam logic [ADDR_W-4:0] c_status_word = EMIF_STATUS_OFFSET[ADDR_W-1:3];
    localparam logic [ADDR_W-4:0] c_cap_word    = EMIF_CAPABILITY_OFFSET[ADDR_W-1:3];
    localparam logic [8:0]        c_mask9       = (9'd1 << NUM_CH) - 9'd1;

    logic [NUM_CH-1:0]   w_success_sync;
    logic [NUM_CH-1:0]   w_fail_sync;
    logic [NUM_CH-1:0]   r_fail_seen;
    logic [NUM_CH-1:0]   w_w1c;
    logic                w_accept;
    logic                w_aligned;
    logic [ADDR_W-4:0]   w_word;
    logic                w_wr_status;
    logic [63:0]         w_rd_data;
    t_emif_status        w_status;
    t_emif_capability    w_cap;
    logic                r_rsp_valid;
    logic [63:0]         r_rsp_data;
    logic [TAG_W-1:0]    r_rsp_tag;
    logic                w_unused;

    // Success and fail flags share one synchroniser instance.
    emif_csr_sync #(
        .WIDTH (2 * NUM_CH)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({cal_fail, cal_success}),
        .q     ({w_fail_sync, w_success_sync})
    );

    assign req_ready   = !r_rsp_valid || rsp_ready;
    assign w_accept    = req_valid && req_ready;
    assign w_aligned   = (req_addr[2:0] == 3'b000);
    assign w_word      = req_addr[ADDR_W-1:3];
    assign w_wr_status = w_accept && req_write && w_aligned && (w_word == c_status_word);
    assign w_w1c       = w_wr_status ? req_wdata[16 +: NUM_CH] : '0;
    assign w_unused    = ^req_wdata;

    always_comb begin
        w_status                    = '0;
        w_status.success[NUM_CH-1:0]   = w_success_sync;
        w_status.fail[NUM_CH-1:0]      = w_fail_sync;
        w_status.fail_seen[NUM_CH-1:0] = r_fail_seen;

        w_cap         = '0;
        w_cap.ch_mask = c_mask9[7:0];
        w_cap.num_ch  = 4'(NUM_CH);

        w_rd_data = '0;
        if (w_aligned) begin
            if (w_word == c_dfh_word) begin
                w_rd_data = DFH_VAL;
            end else if (w_word == c_status_word) begin
                w_rd_data = w_status;
            end else if (w_word == c_cap_word) begin
                w_rd_data = w_cap;
            end
        end
    end

    // A new failure in the same cycle as a W1C keeps the bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail_seen <= '0;
        end else begin
            r_fail_seen <= (r_fail_seen & ~w_w1c) | w_fail_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_tag   <= '0;
        end else if (w_accept && !req_write) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rd_data;
            r_rsp_tag   <= req_tag;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_tag   = r_rsp_tag;

endmodule

`default_nettype wire
